led_scan_controller: RTL and testbench
======================================

Name: led_scan_controller

Overview:
Parametrised successor to the fixed 4-anode scan state machine. It drives NUM_DIGITS active-low digit anodes and a matching segment-select index. It has a built-in refresh prescaler, a per-digit enable mask that skips unused digits, an anti-ghosting blank window at the start of each slot, and a brightness duty control. It sits between the board clock and the seven-segment mux/decoder, which uses seg_sel to pick the nibble for the current digit.

Parameters:
NUM_DIGITS, 4, number of digits/anodes scanned (>=1)
SEL_W, max(1,clog2(NUM_DIGITS)), width of seg_sel (derived, do not override)
REFRESH_DIV, 50000, clk cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 16, cycles at start of each slot with all anodes off (>=0, < REFRESH_DIV)
BRIGHT_W, 3, width of brightness input

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan runs; 0 = scan frozen, display dark
digit_en  in  NUM_DIGITS  per-digit enable mask, bit i = digit i
brightness  in  BRIGHT_W  duty level, 0 = dimmest, all-ones = full
anodes  out  NUM_DIGITS  active-low anode drives, registered
seg_sel  out  SEL_W  index of the digit currently in its slot, registered
slot_start  out  1  one-cycle pulse in the first cycle of every slot, registered

Behaviour:
- Reset (sync, priority over everything): internal slot count k=0, cur=0; seg_sel=0, anodes=all 1, slot_start=0. Reset mid-slot aborts the slot immediately.
- Slot timing: while enable=1, k counts 0..REFRESH_DIV-1. k=0 is the first cycle seg_sel shows the new digit. On k=REFRESH_DIV-1, the next cycle has k=0 and seg_sel = next digit.
- Next digit: lowest index j>cur with digit_en[j]=1, wrapping cyclically through 0. If no other digit is enabled but cur is, cur stays. If digit_en=0, cur holds and anodes stay all 1.
- Index stepping must never leave 0..NUM_DIGITS-1, including non-power-of-2 NUM_DIGITS.
- on_len = ((brightness+1) * (REFRESH_DIV-BLANK_CYCLES)) >> BRIGHT_W, truncating integer arithmetic, intermediate width wide enough for no overflow.
- anodes[cur]=0 iff enable=1, digit_en[cur]=1 and BLANK_CYCLES <= k < BLANK_CYCLES+on_len. All other bits are 1.
- At most one anode is low in any cycle.
- Outputs are computed from next-state (k_next, cur_next) and registered, so anodes and seg_sel change on the same edge. An old digit's anode is never low while seg_sel shows the new digit.
- digit_en and brightness are sampled every cycle. Clearing digit_en[cur] mid-slot turns that anode off on the next edge; the slot still runs to completion.
- slot_start=1 in each cycle with k=0 while enable=1.
- enable=0: k resets to 0 and cur holds. anodes=all 1, slot_start=0. On the first cycle with enable=1, a full new slot begins on the current digit (k=0, slot_start=1).
- Digit 0 after reset: the first slot is on digit 0 even if it is disabled (anode stays off); normal skipping applies from then on.
- NUM_DIGITS=1: seg_sel is constant 0 and slot_start pulses every REFRESH_DIV cycles.

Decomposition:
- Shared package led_pkg: clog2 constant function, ANODE_OFF = 1'b1 polarity constant, default REFRESH_DIV/BLANK_CYCLES values.
- One sub-module, scan_slot_timer: the k counter with enable/reset. It outputs k_next and a wrap flag.
- Digit selection, duty compare and output registers stay in led_scan_controller.

Test Plan:
(Bench params: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=1, BRIGHT_W=2.)
- Full-brightness round robin: reset, then enable=1, digit_en=1111, brightness=3 (on_len=7).
  - seg_sel steps 0,1,2,3,0, each held 8 cycles.
  - In each slot, anodes = 1111 at k=0, then the active-low pattern 1110/1101/1011/0111 for k=1..7.
  - slot_start pulses every 8 cycles.
- Dim levels: brightness=0 gives on_len=1 (anode low at k=1 only); brightness=1 gives on_len=3 (low for k=1..3).
- Skip mask: digit_en=1010 from reset.
  - First slot on digit 0 with anodes 1111.
  - Then seg_sel goes 1,3,1,3 with anodes 1101/0111.
  - Change to 1000 mid-slot of digit 1: anode goes off on the next edge, and the following slots are all digit 3.
- All disabled: digit_en=0000, so anodes stay 1111 and seg_sel holds; setting bit 2 scans 2 only, with anodes=1011 in the on window.
- Enable gating: drop enable at k=4 of digit 2 → next edge anodes=1111, slot_start=0; restore after 10 cycles → seg_sel=2, slot_start=1, full 8-cycle slot.
- Reset mid-slot: assert reset at k=5 of digit 3 → next edge seg_sel=0, anodes=1111, slot_start=0; after release, the slot on digit 0 starts clean.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED digit scan controller.
package led_pkg;

   localparam logic ANODE_OFF        = 1'b1;
   localparam int   DEF_REFRESH_DIV  = 50000;
   localparam int   DEF_BLANK_CYCLES = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot cycle counter; restarts a fresh slot at k=0 whenever the scan resumes.
module scan_slot_timer
   import led_pkg::*;
#(
   parameter int REFRESH_DIV = DEF_REFRESH_DIV,
   parameter int K_W         = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV)
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           enable_i,
   output logic [K_W-1:0] k_next_o,
   output logic           wrap_o
);

   localparam logic [K_W-1:0] K_LAST = K_W'(REFRESH_DIV - 1);

   logic [K_W-1:0] k_q;
   logic           run_q;

   // run_q remembers the previous enable so the first enabled cycle lands on k=0
   always_comb begin
      wrap_o   = enable_i && run_q && (k_q == K_LAST);
      k_next_o = '0;
      if (enable_i && run_q && !wrap_o)
         k_next_o = k_q + K_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         k_q   <= '0;
         run_q <= 1'b0;
      end else begin
         k_q   <= k_next_o;
         run_q <= enable_i;
      end
   end

endmodule

// File: rtl/led_scan_controller.sv
// Multiplexed seven-segment digit scanner with skip mask, blanking window and
// brightness duty; all outputs are registered from the next-state values.
module led_scan_controller
   import led_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SEL_W        = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS),
   parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int BRIGHT_W     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_DIGITS-1:0] digit_en,
   input  logic [BRIGHT_W-1:0]   brightness,
   output logic [NUM_DIGITS-1:0] anodes,
   output logic [SEL_W-1:0]      seg_sel,
   output logic                  slot_start
);

   localparam int K_W    = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);
   localparam int PROD_W = BRIGHT_W + 33;

   logic [K_W-1:0]        k_next;
   logic                  wrap;
   logic [SEL_W-1:0]      cur_q, cur_d, nxt_dig;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic                  slot_start_q, slot_start_d;
   logic                  found_above, found_wrap;
   logic [SEL_W-1:0]      dig_above, dig_wrap;
   logic                  en_cur, in_win, lit;
   logic [PROD_W-1:0]     prod, on_len, k_ext;

   scan_slot_timer #(
      .REFRESH_DIV (REFRESH_DIV),
      .K_W         (K_W)
   ) u_timer (
      .clk_i    (clk),
      .reset_i  (reset),
      .enable_i (enable),
      .k_next_o (k_next),
      .wrap_o   (wrap)
   );

   // Descending scan so the last hit is the lowest index; the wrap candidate
   // includes cur itself, which covers the "only cur enabled" case.
   always_comb begin
      found_above = 1'b0;
      found_wrap  = 1'b0;
      dig_above   = '0;
      dig_wrap    = '0;
      for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
         if (digit_en[j]) begin
            if (j > int'(cur_q)) begin
               found_above = 1'b1;
               dig_above   = SEL_W'(j);
            end else begin
               found_wrap = 1'b1;
               dig_wrap   = SEL_W'(j);
            end
         end
      end
      nxt_dig = found_above ? dig_above : (found_wrap ? dig_wrap : cur_q);
   end

   always_comb begin
      cur_d  = wrap ? nxt_dig : cur_q;
      en_cur = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (cur_d == SEL_W'(i)) en_cur = digit_en[i];

      prod   = (PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(REFRESH_DIV - BLANK_CYCLES);
      on_len = prod >> BRIGHT_W;
      k_ext  = PROD_W'(k_next);
      in_win = (k_ext >= PROD_W'(BLANK_CYCLES)) && (k_ext < PROD_W'(BLANK_CYCLES) + on_len);
      lit    = enable && en_cur && in_win;

      for (int i = 0; i < NUM_DIGITS; i++)
         anodes_d[i] = (lit && (cur_d == SEL_W'(i))) ? ~ANODE_OFF : ANODE_OFF;
      slot_start_d = enable && (k_next == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q        <= '0;
         anodes_q     <= {NUM_DIGITS{ANODE_OFF}};
         slot_start_q <= 1'b0;
      end else begin
         cur_q        <= cur_d;
         anodes_q     <= anodes_d;
         slot_start_q <= slot_start_d;
      end
   end

   assign anodes     = anodes_q;
   assign seg_sel    = cur_q;
   assign slot_start = slot_start_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Scoreboard bench: a slot/digit reference model queues expected outputs per
// cycle, and a monitor compares them against the registered DUT outputs.
module tb_led_scan_controller;

   localparam int N  = 4;
   localparam int RD = 8;
   localparam int BC = 1;
   localparam int BW = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] digit_en = 4'h0;
   logic [1:0] brightness = 2'd0;
   logic [3:0] anodes;
   logic [1:0] seg_sel;
   logic       slot_start;

   led_scan_controller #(
      .NUM_DIGITS   (N),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC),
      .BRIGHT_W     (BW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .digit_en   (digit_en),
      .brightness (brightness),
      .anodes     (anodes),
      .seg_sel    (seg_sel),
      .slot_start (slot_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [1:0] sel;
      logic       ss;
      string      tag;
   } exp_t;

   exp_t  q[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   string phase = "reset";

   // Reference model: position within slot, digit on display, scan running
   int m_pos = 0;
   int m_dig = 0;
   bit m_on = 1'b0;

   function automatic int next_dig(input int cur, input logic [3:0] en);
      for (int d = 1; d <= N; d++) begin
         int j;
         j = (cur + d) % N;
         if (((en >> j) & 4'd1) != 4'd0) return j;
      end
      return cur;
   endfunction

   task automatic check(input string nm, input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%s] cycle %0d: got %0h expected %0h", nm, tag, cyc, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit e, input logic [3:0] de, input logic [1:0] br);
      exp_t x;
      int   on_len;
      bit   low;
      @(negedge clk);
      reset = r; enable = e; digit_en = de; brightness = br;
      x.an = 4'hF; x.sel = 2'd0; x.ss = 1'b0;
      if (r) begin
         m_pos = 0; m_dig = 0; m_on = 1'b0;
      end else if (!e) begin
         m_pos = 0; m_on = 1'b0;
         x.sel = 2'(m_dig);
      end else begin
         if (m_on) begin
            m_pos++;
            if (m_pos == RD) begin
               m_pos = 0;
               m_dig = next_dig(m_dig, de);
            end
         end else begin
            m_pos = 0;
         end
         m_on   = 1'b1;
         on_len = ((int'(br) + 1) * (RD - BC)) / (1 << BW);
         low    = (((de >> m_dig) & 4'd1) != 4'd0) && (m_pos >= BC) && (m_pos < BC + on_len);
         if (low) x.an = 4'hF & ~(4'b0001 << m_dig);
         x.sel = 2'(m_dig);
         x.ss  = (m_pos == 0);
      end
      x.tag = phase;
      q.push_back(x);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      cyc++;
      if (q.size() > 0) begin
         x = q.pop_front();
         check("anodes", x.tag, 8'(anodes), 8'(x.an));
         check("seg_sel", x.tag, 8'(seg_sel), 8'(x.sel));
         check("slot_start", x.tag, 8'(slot_start), 8'(x.ss));
      end
   end

   initial begin
      logic [3:0] rde;
      logic [1:0] rbr;
      step(1, 0, 4'h0, 2'd0);
      step(1, 0, 4'h0, 2'd0);

      phase = "full";
      repeat (40) step(0, 1, 4'hF, 2'd3);
      phase = "dim0";
      repeat (16) step(0, 1, 4'hF, 2'd0);
      phase = "dim1";
      repeat (16) step(0, 1, 4'hF, 2'd1);

      phase = "skip";
      step(1, 0, 4'b1010, 2'd3);
      repeat (28) step(0, 1, 4'b1010, 2'd3);
      phase = "skip1000";
      repeat (30) step(0, 1, 4'b1000, 2'd3);

      phase = "alloff";
      repeat (20) step(0, 1, 4'b0000, 2'd3);
      phase = "only2";
      repeat (24) step(0, 1, 4'b0100, 2'd3);

      phase = "gate";
      for (int i = 0; i < 16 && !(m_dig == 2 && m_pos == 3); i++) step(0, 1, 4'b0100, 2'd3);
      repeat (10) step(0, 0, 4'b0100, 2'd3);
      repeat (16) step(0, 1, 4'b0100, 2'd3);

      phase = "rstmid";
      for (int i = 0; i < 64 && !(m_dig == 3 && m_pos == 4); i++) step(0, 1, 4'hF, 2'd3);
      step(1, 1, 4'hF, 2'd3);
      repeat (16) step(0, 1, 4'hF, 2'd3);

      phase = "random";
      rde = 4'hF;
      rbr = 2'd3;
      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) rde = 4'($urandom);
         if ($urandom_range(0, 19) == 0) rbr = 2'($urandom);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0, rde, rbr);
      end

      @(negedge clk);
      @(negedge clk);
      check("drain", "end", 8'(q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
